// File: rtl/prim_and2_filter.sv
// -----------------------------------------------------------------------------
// prim_and2_filter
//
// Registered per-bit glitch filter placed after a 2-input AND. The AND result
// is registered (raw stage). A bit of out_o only takes a new value once the
// raw bit has disagreed with it for Cycles consecutive enabled clocks.
// Multi-source enables, such as lifecycle or escalation enables, pass through
// this block before they reach control logic.
//
// Parameters:
//   Width      - number of independent bits filtered
//   Cycles     - consecutive cycles of disagreement before a bit flips (>= 1)
//   ResetValue - reset value of the raw register and of out_o
//
// Ports:
//   clk_i   in   1      clock, rising edge
//   rst_i   in   1      synchronous active-high reset
//   en_i    in   1      filter enable; 0 = registered pass-through of raw
//   in0_i   in   Width  AND operand 0
//   in1_i   in   Width  AND operand 1
//   out_o   out  Width  filtered, registered AND result
//   busy_o  out  1      some bit has a pending change (raw != out)
//
// Optional build macro PRIM_AND2_FILTER_EDGE_EN adds:
//   rise_o  out  Width  one-cycle pulse in the cycle out_o[b] goes 0->1
//   fall_o  out  Width  one-cycle pulse in the cycle out_o[b] goes 1->0
// -----------------------------------------------------------------------------
module prim_and2_filter #(
  parameter int              Width      = 1,
  parameter int              Cycles     = 4,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] in0_i,
  input  logic [Width-1:0] in1_i,
  output logic [Width-1:0] out_o,
  output logic             busy_o
`ifdef PRIM_AND2_FILTER_EDGE_EN
  ,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
`endif
);

  // A counter wide enough to hold 0..Cycles.
  localparam int CntW = (Cycles < 1) ? 1 : $clog2(Cycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

  if (Cycles < 1) begin : g_bad_cycles
    $error("prim_and2_filter: Cycles must be >= 1");
  end

  logic [Width-1:0] w_and;
  logic [Width-1:0] r_raw_p0;
  logic [Width-1:0] r_out_p1;
  logic [CntW-1:0]  r_cnt_p1 [Width];
  logic [Width-1:0] w_out_nxt;
  logic [CntW-1:0]  w_cnt_nxt [Width];

  assign w_and = in0_i & in1_i;

  // ---- Stage p0: register the raw AND result --------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_raw_p0 <= ResetValue;
    end else begin
      r_raw_p0 <= w_and;
    end
  end

  // ---- Stage p1: per-bit disagreement counters and filtered output ----------
  // A counter value of k means raw has disagreed with out for k+1 enabled
  // edges so far, so the flip happens on the edge that finds k == Cycles-1.
  // Any agreement, a disabled edge, or the flip itself restarts from zero.
  always_comb begin
    w_out_nxt = r_out_p1;
    for (int b = 0; b < Width; b++) begin
      w_cnt_nxt[b] = '0;
      if (!en_i) begin
        w_out_nxt[b] = r_raw_p0[b];
      end else if (r_raw_p0[b] != r_out_p1[b]) begin
        if (r_cnt_p1[b] == CntLast) begin
          w_out_nxt[b] = r_raw_p0[b];
        end else begin
          w_cnt_nxt[b] = r_cnt_p1[b] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_p1 <= ResetValue;
      for (int b = 0; b < Width; b++) begin
        r_cnt_p1[b] <= '0;
      end
    end else begin
      r_out_p1 <= w_out_nxt;
      for (int b = 0; b < Width; b++) begin
        r_cnt_p1[b] <= w_cnt_nxt[b];
      end
    end
  end

  assign out_o  = r_out_p1;
  // Built from registered state only, so no input reaches busy_o directly.
  assign busy_o = |(r_raw_p0 ^ r_out_p1);

`ifdef PRIM_AND2_FILTER_EDGE_EN
  logic [Width-1:0] r_rise_p1;
  logic [Width-1:0] r_fall_p1;

  // Edge pulses are registered alongside out so they coincide with the
  // cycle in which out_o shows its new value, in either mode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rise_p1 <= '0;
      r_fall_p1 <= '0;
    end else begin
      r_rise_p1 <= w_out_nxt & ~r_out_p1;
      r_fall_p1 <= ~w_out_nxt & r_out_p1;
    end
  end

  assign rise_o = r_rise_p1;
  assign fall_o = r_fall_p1;
`endif

endmodule
